// File: rtl/frame_sequencer.sv
// frame_sequencer: issues paired reader/writer frame commands, rotating
// through NBUF buffers per base address, for a programmed number of frames
// or until stopped.
module frame_sequencer #(
    parameter int NBUF = 3
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] cfg_rd_base,
    input  logic [31:0] cfg_wr_base,
    input  logic [31:0] cfg_rd_bytes,
    input  logic [31:0] cfg_wr_bytes,
    input  logic [31:0] cfg_num_frames,
    output logic        rd_frame_valid,
    input  logic        rd_frame_ready,
    output logic [31:0] rd_buf_addr,
    output logic [31:0] rd_frame_bytes,
    output logic        wr_frame_valid,
    input  logic        wr_frame_ready,
    output logic [31:0] wr_buf_addr,
    output logic [31:0] wr_frame_bytes,
    output logic        busy,
    output logic [3:0]  buf_idx,
    output logic [31:0] frame_count,
    output logic        seq_done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        GUARD    = 2'd2,
        RUN      = 2'd3
    } state_t;

    state_t      state_r;
    logic        start_q_r;
    logic        stop_q_r;
    logic        stop_pending_r;
    logic [31:0] rd_base_r;
    logic [31:0] wr_base_r;
    logic [31:0] num_frames_r;
    logic [31:0] rd_off_r;
    logic [31:0] wr_off_r;

    logic        start_edge_s;
    logic        stop_edge_s;
    logic        both_ready_s;
    logic        last_buf_s;
    logic        finish_s;
    logic        issue_s;
    logic [31:0] next_count_s;
    logic [31:0] rd_off_next_s;
    logic [31:0] wr_off_next_s;

    // Edge detection, completion bookkeeping and the command handshake.
    // A stop edge in DISPATCH wins over a same-cycle handshake, so no
    // command is issued on the cycle the sequence is abandoned.
    always_comb begin
        start_edge_s = start & ~start_q_r;
        stop_edge_s  = stop & ~stop_q_r;
        both_ready_s = rd_frame_ready & wr_frame_ready;
        last_buf_s   = (buf_idx == 4'(NBUF - 1));
        next_count_s = frame_count + 32'd1;
        if (last_buf_s) begin
            rd_off_next_s = 32'd0;
            wr_off_next_s = 32'd0;
        end else begin
            rd_off_next_s = rd_off_r + rd_frame_bytes;
            wr_off_next_s = wr_off_r + wr_frame_bytes;
        end
        finish_s = stop_pending_r | stop_edge_s |
                   ((num_frames_r != 32'd0) && (next_count_s == num_frames_r));
        issue_s  = (state_r == DISPATCH) && both_ready_s && !stop_edge_s;
        rd_frame_valid = issue_s;
        wr_frame_valid = issue_s;
    end

    // Sequencer state, latched configuration and registered outputs.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            start_q_r      <= 1'b0;
            stop_q_r       <= 1'b0;
            stop_pending_r <= 1'b0;
            rd_base_r      <= 32'd0;
            wr_base_r      <= 32'd0;
            num_frames_r   <= 32'd0;
            rd_off_r       <= 32'd0;
            wr_off_r       <= 32'd0;
            rd_buf_addr    <= 32'd0;
            wr_buf_addr    <= 32'd0;
            rd_frame_bytes <= 32'd0;
            wr_frame_bytes <= 32'd0;
            busy           <= 1'b0;
            buf_idx        <= 4'd0;
            frame_count    <= 32'd0;
            seq_done       <= 1'b0;
        end else begin
            start_q_r <= start;
            stop_q_r  <= stop;
            seq_done  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_edge_s && !stop_edge_s) begin
                        rd_base_r      <= cfg_rd_base;
                        wr_base_r      <= cfg_wr_base;
                        num_frames_r   <= cfg_num_frames;
                        rd_frame_bytes <= cfg_rd_bytes;
                        wr_frame_bytes <= cfg_wr_bytes;
                        rd_buf_addr    <= cfg_rd_base;
                        wr_buf_addr    <= cfg_wr_base;
                        rd_off_r       <= 32'd0;
                        wr_off_r       <= 32'd0;
                        frame_count    <= 32'd0;
                        buf_idx        <= 4'd0;
                        stop_pending_r <= 1'b0;
                        busy           <= 1'b1;
                        state_r        <= DISPATCH;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                DISPATCH: begin
                    if (stop_edge_s) begin
                        stop_pending_r <= 1'b0;
                        busy           <= 1'b0;
                        seq_done       <= 1'b1;
                        state_r        <= IDLE;
                    end else if (both_ready_s) begin
                        state_r <= GUARD;
                    end else begin
                        state_r <= DISPATCH;
                    end
                end
                GUARD: begin
                    // Engines drop ready for one cycle after accepting.
                    if (stop_edge_s) begin
                        stop_pending_r <= 1'b1;
                    end
                    state_r <= RUN;
                end
                RUN: begin
                    if (both_ready_s) begin
                        frame_count <= next_count_s;
                        buf_idx     <= last_buf_s ? 4'd0 : (buf_idx + 4'd1);
                        rd_off_r    <= rd_off_next_s;
                        wr_off_r    <= wr_off_next_s;
                        rd_buf_addr <= rd_base_r + rd_off_next_s;
                        wr_buf_addr <= wr_base_r + wr_off_next_s;
                        if (finish_s) begin
                            stop_pending_r <= 1'b0;
                            busy           <= 1'b0;
                            seq_done       <= 1'b1;
                            state_r        <= IDLE;
                        end else begin
                            state_r <= DISPATCH;
                        end
                    end else begin
                        if (stop_edge_s) begin
                            stop_pending_r <= 1'b1;
                        end
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Schedules repeated frame transfers through the DRAM read → app → DRAM write pipeline. It hands the DramReader and DramWriterBuf a paired frame command, with buffer address and byte count, for each frame, and rotates through NBUF buffers per base address. It runs for a programmed number of frames or until stopped. It sits between the MMIO command decode and the two engines' frame-command ports.

## Interface
- NBUF, 3: number of buffers rotated per base address; 1..16.
- fclk  in  1: clock.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: level (MMIO_CMD==CMD_START); acted on at its rising edge.
- stop  in  1: level (MMIO_CMD==CMD_STOP); acted on at its rising edge.
- cfg_rd_base  in  32: reader buffer-0 byte address.
- cfg_wr_base  in  32: writer buffer-0 byte address.
- cfg_rd_bytes  in  32: reader frame size in bytes; also the reader buffer stride.
- cfg_wr_bytes  in  32: writer frame size in bytes; also the writer buffer stride.
- cfg_num_frames  in  32: frames to run; 0 = run until stop.
- rd_frame_valid  out  1: frame command to the reader.
- rd_frame_ready  in  1: reader idle and able to accept a command.
- rd_buf_addr  out  32: reader frame address.
- rd_frame_bytes  out  32: reader frame size.
- wr_frame_valid  out  1: frame command to the writer.
- wr_frame_ready  in  1: writer idle and able to accept a command.
- wr_buf_addr  out  32: writer frame address.
- wr_frame_bytes  out  32: writer frame size.
- busy  out  1: high whenever the state is not IDLE.
- buf_idx  out  4: buffer index of the current or next frame.
- frame_count  out  32: frames completed since the last accepted start.
- seq_done  out  1: one-cycle pulse when a sequence ends.

## Operation
- Rising edges are detected against start_q/stop_q, which are registered copies of start/stop. Both copies reset to 0.
- States: IDLE, DISPATCH, GUARD, RUN.
- IDLE, start edge with no stop edge in the same cycle:
  - Latch all cfg_* inputs.
  - Clear frame_count, buf_idx, the address offsets and stop_pending.
  - Load rd_buf_addr=cfg_rd_base, wr_buf_addr=cfg_wr_base, and the byte outputs.
  - Go to DISPATCH.
- IDLE, stop edge: ignored. A simultaneous start edge and stop edge in IDLE: stay in IDLE.
- DISPATCH:
  - rd_frame_valid = wr_frame_valid = rd_frame_ready & wr_frame_ready. Both commands are always issued in the same cycle, never one alone.
  - When both readies are high, go to GUARD.
- GUARD: exactly one cycle, then RUN. It covers the engines' one-cycle ready drop after accepting a command.
- RUN: wait until rd_frame_ready & wr_frame_ready; that cycle is frame completion. On completion:
  - frame_count+1.
  - buf_idx = (buf_idx==NBUF-1) ? 0 : buf_idx+1.
  - Offsets advance by the latched byte counts, or reset to 0 on wrap. Outputs become base+offset, with 32-bit modulo-2^32 add and no multiplier.
  - If stop_pending, or cfg_num_frames!=0 and the new frame_count==cfg_num_frames: go to IDLE and pulse seq_done. Otherwise go to DISPATCH.
- Stop edge in DISPATCH, GUARD or RUN sets stop_pending.
  - A frame already handed to the engines always finishes; there is no abort.
  - Stop during DISPATCH before the handshake: go to IDLE next cycle, pulse seq_done, no command issued.
- Start edges outside IDLE are ignored. cfg_* changes after start have no effect until the next start.
- frame_count wraps modulo 2^32 in continuous mode.

## Timing
- Reset values: all outputs 0 (valids 0, addresses 0, byte counts 0, busy 0, buf_idx 0, frame_count 0, seq_done 0); state IDLE; start_q=stop_q=0.
- Reset is asynchronous. Asserting it mid-frame returns everything to reset values immediately. Engine cleanup is the engines' own responsibility.
- Start edge sampled at cycle T → busy and DISPATCH from T+1. Valids can be high at T+1 if both readies are high.
- Address and byte outputs are registered and stable for the whole of DISPATCH.
- Completion in RUN at cycle C → next DISPATCH at C+1 with the new addresses. seq_done and busy=0 appear together at C+1.
- Each valid is high for exactly one cycle per frame.

## Test plan
- Basic run: NBUF=3, rd_base=0x1000_0000, wr_base=0x2000_0000, bytes=0x100, num_frames=4, engines idle-ready with a 10-cycle busy per frame.
  - Required: 4 paired valid pulses.
  - rd addresses 0x1000_0000, 0x1000_0100, 0x1000_0200, 0x1000_0000.
  - wr addresses track the same pattern at the 0x2000_0000 base.
  - frame_count ends at 4; one seq_done pulse.
- Ready skew: wr_frame_ready held low for 20 cycles after start.
  - Required: neither valid asserts until both readies are high; then both assert in the same cycle.
- Stop mid-frame: num_frames=0, stop edge during the second frame's RUN.
  - Required: the frame completes, frame_count=2, no third valid, seq_done pulses.
- Start while busy, and simultaneous start+stop in IDLE.
  - Required: no restart, frame_count not cleared; the simultaneous case stays IDLE with busy=0.
- Reset mid-sequence: assert rst during RUN.
  - Required: all outputs 0 asynchronously; after release, a new start begins at buf_idx 0 with the base addresses.
- Wrap: rd_base=0xFFFF_FF00, bytes=0x100, NBUF=2.
  - Required: the second rd address is 0x0000_0000 (modulo 2^32).
